button_event_decoder: RTL

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/btn_pkg.sv | 23 ++
 rtl/evt_buffer.sv | 61 ++++++
 rtl/button_event_decoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event decoder.
//   state_t   : decoder FSM states
//   EVT_*     : 3-bit event codes presented on evt_code
//   CNT_W     : width of the slow-tick counter
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HELD = 3'd2,
      WAIT2     = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   localparam logic [2:0] EVT_NONE   = 3'b000;
   localparam logic [2:0] EVT_SHORT  = 3'b001;
   localparam logic [2:0] EVT_LONG   = 3'b010;
   localparam logic [2:0] EVT_DOUBLE = 3'b011;
   localparam logic [2:0] EVT_REPEAT = 3'b100;

   localparam int CNT_W = 16;

endpackage

// File: rtl/evt_buffer.sv
// One-entry valid/ready holding register for decoded button events.
// Ports:
//   clk_i     : clock (rising edge)
//   rst_i     : synchronous active-high reset
//   push_i    : a new event fires this cycle
//   code_i    : code of the new event
//   ready_i   : consumer accepts the held event when valid_o is also high
//   valid_o   : an event is held
//   code_o    : held event code, 000 when empty
//   dropped_o : one-cycle pulse when a new event was discarded (buffer full)
module evt_buffer (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [2:0] code_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [2:0] code_o,
   output logic       dropped_o
);

   logic       valid_q, valid_d;
   logic [2:0] code_q, code_d;
   logic       dropped_q, dropped_d;

   always_comb begin
      valid_d   = valid_q;
      code_d    = code_q;
      dropped_d = 1'b0;
      if (push_i) begin
         // A full buffer only takes the new event when the old one leaves
         // on this same cycle; otherwise the held event wins.
         if (!valid_q || ready_i) begin
            valid_d = 1'b1;
            code_d  = code_i;
         end else begin
            dropped_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
         code_d  = 3'b000;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q   <= 1'b0;
         code_q    <= 3'b000;
         dropped_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         code_q    <= code_d;
         dropped_q <= dropped_d;
      end
   end

   assign valid_o   = valid_q;
   assign code_o    = code_q;
   assign dropped_o = dropped_q;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into SHORT / LONG / DOUBLE (and optionally
// REPEAT) events, timed in slow_clk ticks, and hands them to a one-entry
// valid/ready buffer.
// Ports:
//   regular_clk : system clock (rising edge)
//   reset       : synchronous active-high reset
//   slow_clk    : one-cycle tick enable
//   btn_level   : debounced button level, 1 = pressed
//   evt_valid   : event pending
//   evt_code    : event code, 000 when nothing pending
//   evt_ready   : consumer accept
//   evt_dropped : pulse when an event is discarded because the buffer is full
// Configuration macro:
//   BTN_AUTOREPEAT_EN : emit REPEAT every REPEAT_TICKS while held after LONG.
module button_event_decoder
   import btn_pkg::*;
#(
   parameter int unsigned LONG_TICKS   = 200,
   parameter int unsigned DOUBLE_TICKS = 60,
   parameter int unsigned REPEAT_TICKS = 40
) (
   input  logic       regular_clk,
   input  logic       reset,
   input  logic       slow_clk,
   input  logic       btn_level,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   input  logic       evt_ready,
   output logic       evt_dropped
);

   localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] DOUBLE_LIM = CNT_W'(DOUBLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_TICKS);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fire;
   logic [2:0]       fire_code;
   logic             rpt_clr;

   always_comb begin
      state_d   = state_q;
      fire      = 1'b0;
      fire_code = EVT_NONE;
      rpt_clr   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_level) state_d = PRESS1;
         end
         PRESS1: begin
            // A release seen on the same cycle the limit is reached still
            // counts as a short press.
            if (!btn_level) begin
               state_d = WAIT2;
            end else if (cnt_q >= LONG_LIM) begin
               fire      = 1'b1;
               fire_code = EVT_LONG;
               state_d   = LONG_HELD;
            end
         end
         LONG_HELD: begin
            if (!btn_level) begin
               state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
            end else if (cnt_q >= REPEAT_LIM) begin
               fire      = 1'b1;
               fire_code = EVT_REPEAT;
               rpt_clr   = 1'b1;
`endif
            end
         end
         WAIT2: begin
            // A second press beats the timeout on the same cycle.
            if (btn_level) begin
               state_d = PRESS2;
            end else if (cnt_q >= DOUBLE_LIM) begin
               fire      = 1'b1;
               fire_code = EVT_SHORT;
               state_d   = IDLE;
            end
         end
         PRESS2: begin
            if (!btn_level) begin
               fire      = 1'b1;
               fire_code = EVT_DOUBLE;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The counter measures time spent in the current state (or since the
      // last REPEAT), so any transition restarts it.
      if ((state_d != state_q) || rpt_clr) begin
         cnt_d = '0;
      end else if (slow_clk && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge regular_clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   evt_buffer u_evt_buffer (
      .clk_i     (regular_clk),
      .rst_i     (reset),
      .push_i    (fire),
      .code_i    (fire_code),
      .ready_i   (evt_ready),
      .valid_o   (evt_valid),
      .code_o    (evt_code),
      .dropped_o (evt_dropped)
   );

endmodule
